// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// The winning request goes through the ALU combinationally and its result
// lands in a one-entry response register with valid/ready handshaking.
// This gives one cycle of latency and a throughput of one operation per cycle.

package riscv_pkg;
  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;
endpackage

// Purely combinational integer ALU.
module alu #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  riscv_pkg::alu_op_e op,
  output logic [XLEN-1:0]   result,
  output logic              zero
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt_s;
  logic           slt_s;
  logic           sltu_s;

  assign shamt_s = b[SHW-1:0];
  assign slt_s   = $signed(a) < $signed(b);
  assign sltu_s  = a < b;

  // Operation select; unknown encodings produce zero.
  always_comb begin
    result = {XLEN{1'b0}};
    case (op)
      riscv_pkg::ALU_ADD:  result = a + b;
      riscv_pkg::ALU_SUB:  result = a - b;
      riscv_pkg::ALU_SLL:  result = a << shamt_s;
      riscv_pkg::ALU_SLT:  result = {{(XLEN-1){1'b0}}, slt_s};
      riscv_pkg::ALU_SLTU: result = {{(XLEN-1){1'b0}}, sltu_s};
      riscv_pkg::ALU_XOR:  result = a ^ b;
      riscv_pkg::ALU_SRL:  result = a >> shamt_s;
      riscv_pkg::ALU_SRA:  result = $signed(a) >>> shamt_s;
      riscv_pkg::ALU_OR:   result = a | b;
      riscv_pkg::ALU_AND:  result = a & b;
      default:             result = {XLEN{1'b0}};
    endcase
  end

  assign zero = (result == {XLEN{1'b0}});
endmodule

module alu_arbiter #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [XLEN-1:0]    req0_a,
  input  logic [XLEN-1:0]    req0_b,
  input  riscv_pkg::alu_op_e req0_op,
  input  logic [TAG_W-1:0]   req0_tag,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [XLEN-1:0]    req1_a,
  input  logic [XLEN-1:0]    req1_b,
  input  riscv_pkg::alu_op_e req1_op,
  input  logic [TAG_W-1:0]   req1_tag,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic [XLEN-1:0]    rsp_result,
  output logic               rsp_zero
);

  logic               accept_ok_s;
  logic               grant0_s;
  logic               grant1_s;
  logic               handshake_s;
  logic               last_grant_r;

  logic [XLEN-1:0]    alu_a_s;
  logic [XLEN-1:0]    alu_b_s;
  riscv_pkg::alu_op_e alu_op_s;
  logic [XLEN-1:0]    alu_result_s;
  logic               alu_zero_s;

  logic               rsp_valid_r;
  logic               rsp_id_r;
  logic [TAG_W-1:0]   rsp_tag_r;
  logic [XLEN-1:0]    rsp_result_r;
  logic               rsp_zero_r;

  // The slot can take a new result when it is empty or being drained now.
  assign accept_ok_s = !rsp_valid_r || rsp_ready;

  // Round-robin grant: a lone requester wins; under contention the one
  // that did not win last time goes next. Nothing is granted in reset.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst_n && accept_ok_s) begin
      if (req0_valid && req1_valid) begin
        if (last_grant_r) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end else if (req0_valid) begin
        grant0_s = 1'b1;
      end else if (req1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready  = grant0_s;
  assign req1_ready  = grant1_s;
  assign handshake_s = grant0_s || grant1_s;

  // Steer the winner's operands to the ALU; requester 0 by default.
  always_comb begin
    alu_a_s  = req0_a;
    alu_b_s  = req0_b;
    alu_op_s = req0_op;
    if (grant1_s) begin
      alu_a_s  = req1_a;
      alu_b_s  = req1_b;
      alu_op_s = req1_op;
    end else begin
      alu_a_s  = req0_a;
      alu_b_s  = req0_b;
      alu_op_s = req0_op;
    end
  end

  alu #(.XLEN(XLEN)) u_alu (
    .a      (alu_a_s),
    .b      (alu_b_s),
    .op     (alu_op_s),
    .result (alu_result_s),
    .zero   (alu_zero_s)
  );

  // Response register: load on a handshake (even while draining), clear
  // valid on a drain without refill, otherwise hold everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_tag_r    <= {TAG_W{1'b0}};
      rsp_result_r <= {XLEN{1'b0}};
      rsp_zero_r   <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (handshake_s) begin
      rsp_valid_r  <= 1'b1;
      rsp_id_r     <= grant1_s;
      rsp_tag_r    <= grant1_s ? req1_tag : req0_tag;
      rsp_result_r <= alu_result_s;
      rsp_zero_r   <= alu_zero_s;
      last_grant_r <= grant1_s;
    end else if (rsp_ready) begin
      rsp_valid_r  <= 1'b0;
    end else begin
      rsp_valid_r  <= rsp_valid_r;
    end
  end

  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_tag    = rsp_tag_r;
  assign rsp_result = rsp_result_r;
  assign rsp_zero   = rsp_zero_r;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL take parameter XLEN, default riscv_pkg XLEN (32), operand/result width.
REQ-002 SHALL take parameter TAG_W, default 4, requester-supplied tag width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1, requester N presents an operation.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1, requester N operation accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, XLEN, operands.
REQ-008 SHALL have ports req0_op / req1_op, input, alu_op_e, operation select.
REQ-009 SHALL have ports req0_tag / req1_tag, input, TAG_W, opaque tag returned with the result.
REQ-010 SHALL have port rsp_valid, output, 1, response register holds a result.
REQ-011 SHALL have port rsp_ready, input, 1, consumer accepts the response.
REQ-012 SHALL have port rsp_id, output, 1, index of the requester that owns the response.
REQ-013 SHALL have port rsp_tag, output, TAG_W, tag of the owning request.
REQ-014 SHALL have ports rsp_result (XLEN) and rsp_zero (1), output, registered ALU result and zero flag.

Function
REQ-015 SHALL instantiate exactly one alu and drive its a, b, op from the granted requester's operands, or from requester 0 when no grant is made.
REQ-016 SHALL define accept_ok = !rsp_valid | rsp_ready (response slot free or draining this cycle).
REQ-017 SHALL grant at most one requester per cycle, and only when accept_ok is 1.
REQ-018 SHALL arbitrate round-robin: with one valid requester, grant it; with both valid, grant the requester other than last_grant.
REQ-019 SHALL assert reqN_ready = grant_N (combinational); handshake completes when reqN_valid & reqN_ready.
REQ-020 SHALL update last_grant only on a completed handshake; idle cycles and stalled cycles leave it unchanged.
REQ-021 SHALL, on a handshake, load rsp_result, rsp_zero, rsp_tag, rsp_id from the alu output and granted requester, and set rsp_valid, giving 1-cycle latency.
REQ-022 SHALL, when rsp_valid & rsp_ready and no new handshake occurs, clear rsp_valid; payload outputs keep their last value.
REQ-023 SHALL, when rsp_valid & !rsp_ready, hold all rsp_* outputs stable and deassert both reqN_ready.
REQ-024 SHALL support drain and refill in the same cycle (rsp_ready=1 with a new grant): rsp_valid stays 1 and the payload is replaced, for full throughput of 1 operation/cycle.
REQ-025 SHALL ignore reqN_a/b/op/tag of requesters that are not granted; non-granted requesters keep their request pending without loss.
REQ-026 SHALL never starve: a continuously valid requester is granted within 2 accepting cycles.
REQ-027 SHALL not assert reqN_ready while reqN_valid is 0.

Reset
REQ-028 SHALL, with rst_n=0 at a rising edge, set rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_tag=0, rsp_id=0, last_grant=1 (requester 0 wins first contention).
REQ-029 SHALL, while rst_n=0, hold req0_ready=req1_ready=0; an in-flight response is discarded by reset.
REQ-030 SHALL accept a request in the first cycle after rst_n returns to 1.

Verification
REQ-031 SHALL cover single request: req0 ADD a=5 b=7 tag=3, rsp_ready=1 -> next cycle rsp_valid=1, rsp_result=12, rsp_zero=0, rsp_id=0, rsp_tag=3.
REQ-032 SHALL cover contention: both valid every cycle after reset, rsp_ready=1 -> grants 0,1,0,1; rsp_id sequence 0,1,0,1 at 1 result/cycle.
REQ-033 SHALL cover backpressure: rsp_ready=0 with result SUB 9-9 held -> rsp_result=0, rsp_zero=1 stable, req0_ready=req1_ready=0 for all stall cycles; release -> pending request accepted same cycle.
REQ-034 SHALL cover signed ops through the arbiter: req1 SLT a=0xFFFFFFFF b=1 -> rsp_result=1; SRA a=0x80000000 b=4 -> rsp_result=0xF8000000.
REQ-035 SHALL cover reset mid-operation: rsp_valid=1 with rsp_ready=0, rst_n=0 one cycle -> rsp_valid=0, all rsp_* zero; after release, contention grants requester 0 first.
